// File: rtl/quad_root_solver_if.sv
// Coefficient/result handshake bundle for quad_root_solver.
// The producer/consumer side uses master; the solver uses slave.
interface quad_root_solver_if #(
  parameter int W = 16
);
  logic                in_valid;
  logic                in_ready;
  logic signed [W-1:0] a;
  logic signed [W-1:0] b;
  logic signed [W-1:0] c;
  logic                out_valid;
  logic                out_ready;
  logic signed [W+1:0] root_1;
  logic signed [W+1:0] root_2;
  logic [2:0]          status;
  logic                exact;

  modport master (
    output in_valid, a, b, c, out_ready,
    input  in_ready, out_valid, root_1, root_2, status, exact
  );

  modport slave (
    input  in_valid, a, b, c, out_ready,
    output in_ready, out_valid, root_1, root_2, status, exact
  );
endinterface

// File: rtl/quad_root_solver.sv
// Handshaked quadratic solver: discriminant, bit-serial sqrt, two bit-serial
// divides, with solution classification and a remainder-free (exact) flag.
module quad_root_solver #(
  parameter int W = 16
) (
  input logic               clk,
  input logic               rst,
  quad_root_solver_if.slave bus
);

  localparam int CW = $clog2(W + 3);

  typedef enum logic [2:0] {IDLE, DISC, SQRT, DIV1, DIV2, DONE} state_t;

  state_t state, state_nx;

  logic signed [W-1:0]   a_r, b_r, c_r;
  logic [CW-1:0]         cnt;
  logic                  sq_last, dv_last;

  logic signed [2*W+2:0] a_x, b_x, c_x, d_calc, d_reg;
  logic [2*W+1:0]        d_abs, sq_rad;

  logic [W+1:0]          sq_rem, sq_rem_nx;
  logic [W:0]            sq_root, sq_root_nx;
  logic [W+3:0]          sq_sh, sq_trial;
  logic                  sq_ge;

  logic [W+2:0]          dv_num, dv_num_nx, dv_rem, dv_rem_nx, dv_den;
  logic [W+3:0]          dv_sh;
  logic                  dv_ge, dv_neg;
  logic signed [W+1:0]   quo_nx, q1;
  logic                  rem1_zero;

  logic signed [W+2:0]   b_w, c_w, a2_w, s1_w, s0_w, num1, num2, den;
  logic                  a_zero, b_zero, d_neg, d_zero, is_degen, is_linear;
  logic [2:0]            status_calc;

  logic signed [W+1:0]   root_1_r, root_2_r;
  logic [2:0]            status_r;
  logic                  exact_r;

  function automatic logic [W+2:0] mag(input logic signed [W+2:0] v);
    mag = v[W+2] ? -v : v;
  endfunction

  assign sq_last = (cnt == CW'(W));
  assign dv_last = (cnt == CW'(W + 2));

  // Discriminant at full width; |D| < 2^(2W+1), so the low 2W+2 bits hold it.
  assign a_x    = {{(W+3){a_r[W-1]}}, a_r};
  assign b_x    = {{(W+3){b_r[W-1]}}, b_r};
  assign c_x    = {{(W+3){c_r[W-1]}}, c_r};
  assign d_calc = b_x * b_x - ((a_x * c_x) <<< 2);
  assign d_abs  = d_calc[2*W+2] ? (2*W+2)'(-d_calc) : d_calc[2*W+1:0];

  assign sq_sh      = {sq_rem, sq_rad[2*W+1:2*W]};
  assign sq_trial   = {1'b0, sq_root, 2'b01};
  assign sq_ge      = (sq_sh >= sq_trial);
  assign sq_rem_nx  = sq_ge ? (W+2)'(sq_sh - sq_trial) : sq_sh[W+1:0];
  assign sq_root_nx = {sq_root[W-1:0], sq_ge};

  assign dv_sh     = {dv_rem, dv_num[W+2]};
  assign dv_ge     = (dv_sh >= {1'b0, dv_den});
  assign dv_rem_nx = dv_ge ? (W+3)'(dv_sh - {1'b0, dv_den}) : dv_sh[W+2:0];
  assign dv_num_nx = {dv_num[W+1:0], dv_ge};
  assign quo_nx    = (W+2)'(dv_neg ? -dv_num_nx : dv_num_nx);

  assign a_zero    = (a_r == '0);
  assign b_zero    = (b_r == '0);
  assign d_neg     = d_reg[2*W+2];
  assign d_zero    = (d_reg == '0);
  assign is_degen  = a_zero && b_zero;
  assign is_linear = a_zero && !b_zero;

  assign b_w  = {{3{b_r[W-1]}}, b_r};
  assign c_w  = {{3{c_r[W-1]}}, c_r};
  assign a2_w = {{2{a_r[W-1]}}, a_r, 1'b0};
  assign s1_w = {2'b00, sq_root_nx};
  assign s0_w = {2'b00, sq_root};

  // Division operands; D==0 falls out of the two-real form because s is 0.
  // The degenerate case divides 0 by 1 so the divider never sees a zero divisor.
  always_comb begin
    num1 = -b_w - s1_w;
    num2 = -b_w + s0_w;
    den  = a2_w;
    if (is_degen) begin
      num1 = '0;
      num2 = '0;
      den  = {{(W+2){1'b0}}, 1'b1};
    end else if (is_linear) begin
      num1 = -c_w;
      num2 = -c_w;
      den  = b_w;
    end else if (d_neg) begin
      num1 = -b_w;
      num2 = s0_w;
    end
  end

  always_comb begin
    status_calc = 3'd0;
    if (is_degen)       status_calc = 3'd4;
    else if (is_linear) status_calc = 3'd3;
    else if (d_neg)     status_calc = 3'd2;
    else if (d_zero)    status_calc = 3'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.in_valid)  state_nx = DISC;
      DISC:                       state_nx = SQRT;
      SQRT:    if (sq_last)       state_nx = DIV1;
      DIV1:    if (dv_last)       state_nx = DIV2;
      DIV2:    if (dv_last)       state_nx = DONE;
      DONE:    if (bus.out_ready) state_nx = IDLE;
      default:                    state_nx = IDLE;
    endcase
  end

  // Every phase runs its full length regardless of status, giving fixed latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r <= '0; b_r <= '0; c_r <= '0;
      cnt <= '0; d_reg <= '0; sq_rad <= '0; sq_rem <= '0; sq_root <= '0;
      dv_num <= '0; dv_rem <= '0; dv_den <= '0; dv_neg <= 1'b0;
      q1 <= '0; rem1_zero <= 1'b0;
      root_1_r <= '0; root_2_r <= '0; status_r <= '0; exact_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_r <= bus.a;
            b_r <= bus.b;
            c_r <= bus.c;
          end
        end
        DISC: begin
          d_reg   <= d_calc;
          sq_rad  <= d_abs;
          sq_rem  <= '0;
          sq_root <= '0;
          cnt     <= '0;
        end
        SQRT: begin
          sq_rad  <= {sq_rad[2*W-1:0], 2'b00};
          sq_rem  <= sq_rem_nx;
          sq_root <= sq_root_nx;
          cnt     <= cnt + CW'(1);
          if (sq_last) begin
            cnt    <= '0;
            dv_num <= mag(num1);
            dv_rem <= '0;
            dv_den <= mag(den);
            dv_neg <= num1[W+2] ^ den[W+2];
          end
        end
        DIV1: begin
          dv_num <= dv_num_nx;
          dv_rem <= dv_rem_nx;
          cnt    <= cnt + CW'(1);
          if (dv_last) begin
            cnt       <= '0;
            q1        <= quo_nx;
            rem1_zero <= (dv_rem_nx == '0);
            dv_num    <= mag(num2);
            dv_rem    <= '0;
            dv_neg    <= num2[W+2] ^ den[W+2];
          end
        end
        DIV2: begin
          dv_num <= dv_num_nx;
          dv_rem <= dv_rem_nx;
          cnt    <= cnt + CW'(1);
          if (dv_last) begin
            cnt      <= '0;
            status_r <= status_calc;
            root_1_r <= is_degen ? '0 : q1;
            root_2_r <= is_degen ? '0 : (is_linear ? q1 : quo_nx);
            if (is_degen)       exact_r <= 1'b0;
            else if (is_linear) exact_r <= rem1_zero;
            else                exact_r <= (sq_rem == '0) && rem1_zero && (dv_rem_nx == '0);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE) && !rst;
  assign bus.out_valid = (state == DONE) && !rst;
  assign bus.root_1    = root_1_r;
  assign bus.root_2    = root_2_r;
  assign bus.status    = status_r;
  assign bus.exact     = exact_r;

endmodule
